run_monitor: RTL and testbench
==============================

// Module: run_monitor
// PURPOSE
//  Synthesizable successor to the bench-side run loop. It watches the CPU SYNC strobe and
//  the active PC, and counts clocks and instructions. Termination is PC >= ROM_SIZE,
//  instruction limit or SYNC stall. It then streams a register-dump index sequence over a
//  valid/ready handshake. Sits beside the cpu in system; drives nothing inside the cpu.
// PARAMETERS
//  PC_WIDTH        12    width of pc input
//  ROM_SIZE        256   first PC value outside ROM; pc >= ROM_SIZE ends the run
//  CYCLES_PER_INSN 8     clocks per machine cycle (SYNC period)
//  MAX_INSNS       4096  instruction limit; reaching it ends the run with limit_hit
//  STALL_CLOCKS    32    clocks without SYNC in RUN that end the run with stalled
//  NUM_DUMP        16    number of dump indices emitted (0..NUM_DUMP-1)
//  COUNT_WIDTH     32    width of clock_count / insn_count
// PORTS
//  clock        input   1               system clock
//  reset        input   1               synchronous, active-low (0 = reset)
//  start        input   1               begin a run (IDLE or DONE only)
//  sync         input   1               cpu SYNC, one clock high per machine cycle
//  pc           input   PC_WIDTH        active program counter (stack top)
//  running      output  1               high in RUN
//  done         output  1               high in DONE
//  limit_hit    output  1               run ended on MAX_INSNS
//  stalled      output  1               run ended on SYNC stall
//  phase        output  $clog2(CPI)     clock phase within machine cycle, 0 on SYNC clock
//  clock_count  output  COUNT_WIDTH     clocks spent in RUN
//  insn_count   output  COUNT_WIDTH     SYNCs sampled in RUN
//  dump_valid   output  1               dump_index valid
//  dump_ready   input   1               consumer accepts dump_index
//  dump_index   output  $clog2(NUM_DUMP) register index being dumped
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; all outputs 0; counters 0. Applies mid-RUN
//    or mid-DUMP; any in-flight dump beat is dropped.
//  - States: IDLE -> RUN -> DUMP -> DONE.
//  - IDLE: start -> RUN next clock; clock_count, insn_count, phase, flags cleared.
//  - RUN:
//    - clock_count += 1 per clock, saturating at all-ones.
//    - phase: on a sync clock the register loads 1 (sync clock itself is phase 0), else
//      phase+1, wrapping CYCLES_PER_INSN-1 -> 0.
//    - On sync: insn_count += 1 (saturating) and pc is sampled the same clock.
//    - If pc >= ROM_SIZE on a sync clock -> DUMP (normal end).
//    - Else if insn_count+1 == MAX_INSNS on that sync -> DUMP with limit_hit=1.
//      Normal end wins over the limit when both occur on the same sync.
//    - STALL: an internal counter clears on sync. Reaching STALL_CLOCKS without sync
//      -> DUMP with stalled=1.
//    - start is ignored in RUN.
//  - DUMP:
//    - dump_valid=1, dump_index starts at 0.
//    - Beat transfers on valid && ready; index increments.
//    - Transfer of index NUM_DUMP-1 -> DONE next clock; dump_valid drops in the same clock.
//    - dump_index is held stable while valid && !ready.
//    - Counters frozen.
//  - DONE:
//    - done=1; flags and counters hold.
//    - start -> RUN with counters and flags cleared (restart).
//  - running/done/dump_valid are mutually exclusive.
//  - Flags are sticky until the next start or reset.
// TESTING
//  1. Reset mid-run: reset=0 for 1 clock during RUN -> next clock IDLE, all outputs 0.
//  2. Normal run: start; sync every 8 clocks; pc 0..4 then pc=256 on sync #6.
//     -> insn_count=6, limit_hit=0, stalled=0, DUMP entered.
//  3. Limit: MAX_INSNS=4, pc<256 always -> DUMP on 4th sync, limit_hit=1.
//     Same bench with pc=256 on 4th sync -> limit_hit=0.
//  4. Stall: sync stops after 2 SYNCs, STALL_CLOCKS=32 -> stalled=1 exactly 32 clocks
//     after last sync; insn_count=2.
//  5. Dump backpressure: dump_ready toggles 1,0,0,1... -> indices 0..15 each exactly once,
//     in order, stable while stalled; done=1 one clock after index 15 accepted.
//  6. Restart: start in DONE -> running=1, clock_count=0, insn_count=0, flags cleared;
//     start asserted in RUN has no effect.

Source files
------------

// File: rtl/run_monitor.sv
// Run supervisor that sits beside the cpu: counts clocks and SYNC-delimited instructions,
// decides when the run ends, then streams register-dump indices over valid/ready.
module run_monitor #(
    parameter int unsigned PC_WIDTH        = 12,
    parameter int unsigned ROM_SIZE        = 256,
    parameter int unsigned CYCLES_PER_INSN = 8,
    parameter int unsigned MAX_INSNS       = 4096,
    parameter int unsigned STALL_CLOCKS    = 32,
    parameter int unsigned NUM_DUMP        = 16,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                sync,
    input  logic [PC_WIDTH-1:0]                 pc,
    output logic                                running,
    output logic                                done,
    output logic                                limit_hit,
    output logic                                stalled,
    output logic [$clog2(CYCLES_PER_INSN)-1:0]  phase,
    output logic [COUNT_WIDTH-1:0]              clock_count,
    output logic [COUNT_WIDTH-1:0]              insn_count,
    output logic                                dump_valid,
    input  logic                                dump_ready,
    output logic [$clog2(NUM_DUMP)-1:0]         dump_index
);

    localparam int unsigned PHW = $clog2(CYCLES_PER_INSN);
    localparam int unsigned DIW = $clog2(NUM_DUMP);
    localparam int unsigned STW = $clog2(STALL_CLOCKS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DUMP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH:0]   INSN_LIMIT = (COUNT_WIDTH + 1)'(MAX_INSNS);
    localparam logic [PC_WIDTH:0]      ROM_LIMIT  = (PC_WIDTH + 1)'(ROM_SIZE);
    localparam logic [PHW-1:0]         PHASE_LAST = PHW'(CYCLES_PER_INSN - 1);
    localparam logic [DIW-1:0]         DUMP_LAST  = DIW'(NUM_DUMP - 1);
    localparam logic [STW-1:0]         STALL_LAST = STW'(STALL_CLOCKS - 1);

    logic [1:0]             state;
    logic [STW-1:0]         stall_cnt;
    logic [COUNT_WIDTH:0]   insn_inc;
    logic                   pc_out;

    // Widened by one bit so the limit compare is exact even at the saturation point.
    always_comb begin
        insn_inc = {1'b0, insn_count} + (COUNT_WIDTH + 1)'(1);
        pc_out   = {1'b0, pc} >= ROM_LIMIT;
    end

    always_comb begin
        running    = (state == S_RUN);
        done       = (state == S_DONE);
        dump_valid = (state == S_DUMP);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            stall_cnt   <= '0;
            phase       <= '0;
            clock_count <= '0;
            insn_count  <= '0;
            limit_hit   <= 1'b0;
            stalled     <= 1'b0;
            dump_index  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        stall_cnt   <= '0;
                        phase       <= '0;
                        clock_count <= '0;
                        insn_count  <= '0;
                        limit_hit   <= 1'b0;
                        stalled     <= 1'b0;
                        dump_index  <= '0;
                    end
                end
                S_RUN: begin
                    if (clock_count != '1)
                        clock_count <= clock_count + CNT_ONE;
                    if (sync) begin
                        phase     <= PHW'(1);
                        stall_cnt <= '0;
                        if (insn_count != '1)
                            insn_count <= insn_count + CNT_ONE;
                        // A PC past ROM is a normal end and takes priority over the limit.
                        if (pc_out) begin
                            state <= S_DUMP;
                        end else if (insn_inc == INSN_LIMIT) begin
                            state     <= S_DUMP;
                            limit_hit <= 1'b1;
                        end
                    end else begin
                        phase <= (phase == PHASE_LAST) ? '0 : phase + PHW'(1);
                        if (stall_cnt == STALL_LAST) begin
                            state   <= S_DUMP;
                            stalled <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + STW'(1);
                        end
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        if (dump_index == DUMP_LAST) begin
                            state      <= S_DONE;
                            dump_index <= '0;
                        end else begin
                            dump_index <= dump_index + DIW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: a default instance plus one built with a 4-instruction limit.
module tb_run_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        sync;
    logic [11:0] pc;
    logic        dump_ready;

    logic        running, done, limit_hit, stalled, dump_valid;
    logic [2:0]  phase;
    logic [31:0] clock_count, insn_count;
    logic [3:0]  dump_index;

    logic        l_running, l_done, l_limit_hit, l_stalled, l_dump_valid;
    logic [2:0]  l_phase;
    logic [31:0] l_clock_count, l_insn_count;
    logic [3:0]  l_dump_index;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clock = ~clock;

    run_monitor dut (
        .clock(clock), .reset(reset), .start(start), .sync(sync), .pc(pc),
        .running(running), .done(done), .limit_hit(limit_hit), .stalled(stalled),
        .phase(phase), .clock_count(clock_count), .insn_count(insn_count),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_index(dump_index)
    );

    run_monitor #(.MAX_INSNS(4)) dut_lim (
        .clock(clock), .reset(reset), .start(start), .sync(sync), .pc(pc),
        .running(l_running), .done(l_done), .limit_hit(l_limit_hit), .stalled(l_stalled),
        .phase(l_phase), .clock_count(l_clock_count), .insn_count(l_insn_count),
        .dump_valid(l_dump_valid), .dump_ready(dump_ready), .dump_index(l_dump_index)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b0;
        start      = 1'b0;
        sync       = 1'b0;
        pc         = '0;
        dump_ready = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic begin_run;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sync_cycle(input logic [11:0] pcv, input int unsigned gap);
        sync = 1'b1;
        pc   = pcv;
        tick();
        sync = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        int unsigned exp_idx;
        int unsigned beats;
        logic        finished;

        // 1: reset mid-run
        do_reset();
        tick();
        begin_run();
        check_val("t1_running", 32'(running), 32'd1);
        sync_cycle(12'd0, 7);
        sync_cycle(12'd1, 3);
        check_val("t1_insn_pre", insn_count, 32'd2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_val("t1_running", 32'(running), 32'd0);
        check_val("t1_done", 32'(done), 32'd0);
        check_val("t1_valid", 32'(dump_valid), 32'd0);
        check_val("t1_phase", 32'(phase), 32'd0);
        check_val("t1_clk", clock_count, 32'd0);
        check_val("t1_insn", insn_count, 32'd0);
        check_val("t1_flags", 32'({limit_hit, stalled}), 32'd0);

        // 2: normal end on pc=256 at sync #6
        do_reset();
        begin_run();
        check_val("t2_clk0", clock_count, 32'd0);
        sync_cycle(12'd0, 0);
        check_val("t2_phase_sync", 32'(phase), 32'd1);
        check_val("t2_insn1", insn_count, 32'd1);
        repeat (7) tick();
        check_val("t2_phase_wrap", 32'(phase), 32'd0);
        for (int i = 1; i < 5; i++) sync_cycle(12'(i), 7);
        check_val("t2_running", 32'(running), 32'd1);
        sync_cycle(12'd256, 0);
        check_val("t2_valid", 32'(dump_valid), 32'd1);
        check_val("t2_running_off", 32'(running), 32'd0);
        check_val("t2_insn", insn_count, 32'd6);
        check_val("t2_clk", clock_count, 32'd41);
        check_val("t2_limit", 32'(limit_hit), 32'd0);
        check_val("t2_stalled", 32'(stalled), 32'd0);
        check_val("t2_index", 32'(dump_index), 32'd0);
        tick();
        check_val("t2_frozen", clock_count, 32'd41);

        // 3: limit of 4 instructions, then pc=256 on the 4th sync
        do_reset();
        begin_run();
        for (int i = 0; i < 3; i++) sync_cycle(12'd0, 7);
        check_val("t3_running", 32'(l_running), 32'd1);
        sync_cycle(12'd0, 0);
        check_val("t3_valid", 32'(l_dump_valid), 32'd1);
        check_val("t3_limit", 32'(l_limit_hit), 32'd1);
        check_val("t3_insn", l_insn_count, 32'd4);
        do_reset();
        begin_run();
        for (int i = 0; i < 3; i++) sync_cycle(12'd0, 7);
        sync_cycle(12'd256, 0);
        check_val("t3b_valid", 32'(l_dump_valid), 32'd1);
        check_val("t3b_limit", 32'(l_limit_hit), 32'd0);

        // 4: stall 32 clocks after the second sync
        do_reset();
        begin_run();
        sync_cycle(12'd0, 7);
        sync_cycle(12'd1, 31);
        check_val("t4_pre_running", 32'(running), 32'd1);
        check_val("t4_pre_stalled", 32'(stalled), 32'd0);
        tick();
        check_val("t4_stalled", 32'(stalled), 32'd1);
        check_val("t4_valid", 32'(dump_valid), 32'd1);
        check_val("t4_insn", insn_count, 32'd2);
        check_val("t4_limit", 32'(limit_hit), 32'd0);

        // 5: dump with ready pattern 1,0,0,...
        exp_idx  = 0;
        beats    = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            dump_ready = (cyc % 3 == 0);
            check_val("t5_valid", 32'(dump_valid), 32'd1);
            check_val("t5_index", 32'(dump_index), exp_idx);
            tick();
            if (dump_ready) begin
                beats++;
                if (exp_idx == 15) finished = 1'b1;
                else exp_idx++;
            end
        end
        dump_ready = 1'b0;
        check_val("t5_finished", 32'(finished), 32'd1);
        check_val("t5_beats", beats, 32'd16);
        check_val("t5_done", 32'(done), 32'd1);
        check_val("t5_valid_off", 32'(dump_valid), 32'd0);

        // 6: DONE holds, then restart; start in RUN is ignored
        tick();
        check_val("t6_done_hold", 32'(done), 32'd1);
        check_val("t6_stall_hold", 32'(stalled), 32'd1);
        check_val("t6_insn_hold", insn_count, 32'd2);
        start = 1'b1;
        tick();
        check_val("t6_running", 32'(running), 32'd1);
        check_val("t6_clk", clock_count, 32'd0);
        check_val("t6_insn", insn_count, 32'd0);
        check_val("t6_flags", 32'({limit_hit, stalled}), 32'd0);
        tick();
        check_val("t6_start_ign", 32'(running), 32'd1);
        check_val("t6_clk1", clock_count, 32'd1);
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
